// File: rtl/led_pwm_pkg.sv
// Shared register map, control bit positions and the perceptual level-to-duty map.
package led_pwm_pkg;

  localparam logic [7:0] REG_TARGET  = 8'h00;
  localparam logic [7:0] REG_CTRL    = 8'h10;
  localparam logic [7:0] REG_FADEDIV = 8'h11;
  localparam logic [7:0] REG_LEVEL   = 8'h20;

  localparam int CTRL_REG_MODE = 0;
  localparam int CTRL_FADE_EN  = 1;

  typedef struct packed {
    logic        full;
    logic [15:0] d16;
  } exp_t;

  // Level 0 is off and 255 is solid on. Other levels use the high nibble as an
  // exponent and the low nibble as a mantissa under an implied leading one.
  function automatic exp_t exp_map(input logic [7:0] level);
    exp_t        r;
    logic [15:0] base;
    r.full = 1'b0;
    r.d16  = 16'h0000;
    base   = {1'b1, level[3:0], 11'b0};
    if (level == 8'hFF) begin
      r.full = 1'b1;
    end else if (level != 8'h00) begin
      r.d16 = base >> (4'd15 - level[7:4]);
    end
    return r;
  endfunction

endpackage

// File: rtl/led_pwm_fader_array_if.sv
// Register bus as seen from the I2C slave application side.
// Handshake: wen is a single-cycle write strobe with addr/wdata valid in the same
// cycle (always accepted, no ready); rdata is combinational from addr at all times.
interface led_pwm_fader_array_if;
  logic       wen;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;

  modport master (output wen, output addr, output wdata, input rdata);
  modport slave  (input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: target register, slewing fader, exp map, wrap-aligned shadow
// duty and output comparator.
module led_pwm_channel
  import led_pwm_pkg::*;
#(
  parameter int PWM_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PWM_W-1:0] cnt_i,
  input  logic             wrap_i,
  input  logic             fade_en_i,
  input  logic             fade_step_i,
  input  logic             tgt_we_i,
  input  logic [7:0]       tgt_wdata_i,
  input  logic             man_we_i,
  input  logic [7:0]       man_data_i,
  output logic [7:0]       target_o,
  output logic [7:0]       level_o,
  output logic             pwm_o
);

  logic [7:0]       target_q;
  logic [7:0]       level_q, level_d;
  logic [PWM_W-1:0] act_duty_q;
  logic             act_full_q;
  logic             pwm_q;
  exp_t             em;
  logic [PWM_W-1:0] duty_c;

  // Target register: a bus write takes priority over the manual fan-out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             target_q <= 8'h00;
    else if (tgt_we_i)      target_q <= tgt_wdata_i;
    else if (man_we_i)      target_q <= man_data_i;
  end

  // Fader: follow target directly, or step by one toward the registered target.
  always_comb begin
    level_d = level_q;
    if (!fade_en_i) begin
      level_d = target_q;
    end else if (fade_step_i) begin
      if (level_q < target_q)      level_d = level_q + 8'd1;
      else if (level_q > target_q) level_d = level_q - 8'd1;
    end
  end

  // Level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) level_q <= 8'h00;
    else        level_q <= level_d;
  end

  // Exp map of the current level, scaled to the counter width.
  always_comb begin
    em     = exp_map(level_q);
    duty_c = PWM_W'(em.d16 >> (16 - PWM_W));
  end

  // Shadow duty: only reloaded on the wrap cycle so a period is never cut short.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_duty_q <= '0;
      act_full_q <= 1'b0;
    end else if (wrap_i) begin
      act_duty_q <= duty_c;
      act_full_q <= em.full;
    end
  end

  // Registered compare output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pwm_q <= 1'b0;
    else        pwm_q <= act_full_q | (cnt_i < act_duty_q);
  end

  assign target_o = target_q;
  assign level_o  = level_q;
  assign pwm_o    = pwm_q;

endmodule

// File: rtl/led_pwm_fader_array.sv
// N-channel LED PWM engine: shared period counter, fade prescaler, control
// registers, manual brightness fan-out and register read mux.
module led_pwm_fader_array
  import led_pwm_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int PWM_W = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  led_pwm_fader_array_if.slave   bus,
  input  logic [7:0]             manual_in,
  output logic [NCH-1:0]         pwm_out,
  output logic                   period_tick
);

  localparam logic [4:0] NCH_L = 5'(NCH);

  logic [PWM_W-1:0] cnt_q;
  logic [7:0]       presc_q;
  logic             reg_mode_q, fade_en_q;
  logic [7:0]       fade_div_q;
  logic             wrap, fade_step, man_we;
  logic [7:0]       eff_div;
  logic [3:0]       addr_ch;
  logic             ch_in_range, is_target, is_level;
  logic [7:0]       rdata_c;
  logic [7:0]       target_w [NCH];
  logic [7:0]       level_w  [NCH];

  assign wrap        = (cnt_q == {PWM_W{1'b1}});
  assign period_tick = wrap;
  assign eff_div     = (fade_div_q == 8'd0) ? 8'd1 : fade_div_q;
  assign fade_step   = wrap && (presc_q >= eff_div - 8'd1);
  assign man_we      = !reg_mode_q && !bus.wen;
  assign addr_ch     = bus.addr[3:0];
  assign ch_in_range = ({1'b0, addr_ch} < NCH_L);
  assign is_target   = (bus.addr[7:4] == REG_TARGET[7:4]) && ch_in_range;
  assign is_level    = (bus.addr[7:4] == REG_LEVEL[7:4]) && ch_in_range;

  // Free-running period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_q + 1'b1;
  end

  // Prescaler: counts period ticks and reloads on each fade step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= 8'd0;
    end else if (wrap) begin
      if (fade_step) presc_q <= 8'd0;
      else           presc_q <= presc_q + 8'd1;
    end
  end

  // Control registers; any target write switches the block into register mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_mode_q <= 1'b0;
      fade_en_q  <= 1'b0;
      fade_div_q <= 8'd1;
    end else if (bus.wen) begin
      if (bus.addr == REG_CTRL) begin
        reg_mode_q <= bus.wdata[CTRL_REG_MODE];
        fade_en_q  <= bus.wdata[CTRL_FADE_EN];
      end else if (bus.addr == REG_FADEDIV) begin
        fade_div_q <= bus.wdata;
      end else if (is_target) begin
        reg_mode_q <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic       tgt_we;
    logic [7:0] man_data;

    assign tgt_we   = bus.wen && is_target && (addr_ch == 4'(i));
    assign man_data = (manual_in == 8'd0) ? 8'd0 : (manual_in ^ {1'b0, 3'(i), 4'b0});

    led_pwm_channel #(.PWM_W(PWM_W)) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .cnt_i       (cnt_q),
      .wrap_i      (wrap),
      .fade_en_i   (fade_en_q),
      .fade_step_i (fade_step),
      .tgt_we_i    (tgt_we),
      .tgt_wdata_i (bus.wdata),
      .man_we_i    (man_we),
      .man_data_i  (man_data),
      .target_o    (target_w[i]),
      .level_o     (level_w[i]),
      .pwm_o       (pwm_out[i])
    );
  end

  // Combinational read mux; unmapped addresses read zero.
  always_comb begin
    rdata_c = 8'h00;
    if (bus.addr == REG_CTRL) begin
      rdata_c = {6'b0, fade_en_q, reg_mode_q};
    end else if (bus.addr == REG_FADEDIV) begin
      rdata_c = fade_div_q;
    end else if (is_target) begin
      for (int i = 0; i < NCH; i++) begin
        if (addr_ch == 4'(i)) rdata_c = target_w[i];
      end
    end else if (is_level) begin
      for (int i = 0; i < NCH; i++) begin
        if (addr_ch == 4'(i)) rdata_c = level_w[i];
      end
    end
  end

  assign bus.rdata = rdata_c;

endmodule

// File: tb/tb_led_pwm_fader_array.sv
// Directed bench for led_pwm_fader_array with an 8-bit PWM counter (256-clock period).
module tb_led_pwm_fader_array;

  localparam int NCH    = 8;
  localparam int PWM_W  = 8;
  localparam int PERIOD = 256;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     manual_in;
  logic [NCH-1:0] pwm_out;
  logic           period_tick;

  int checks   = 0;
  int failures = 0;

  led_pwm_fader_array_if bus_if ();

  led_pwm_fader_array #(.NCH(NCH), .PWM_W(PWM_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .manual_in   (manual_in),
    .pwm_out     (pwm_out),
    .period_tick (period_tick)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] manual;
    logic       do_wr;
    logic [7:0] wa;
    logic [7:0] wd;
    logic [7:0] ra;
    logic [7:0] exp;
    string      name;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.wen   = 1'b1;
    bus_if.addr  = a;
    bus_if.wdata = d;
    @(negedge clk);
    bus_if.wen   = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bus_if.addr = a;
    #1;
    d = bus_if.rdata;
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < PERIOD + 10);
    check("tick_seen", {31'b0, period_tick}, 32'd1);
  endtask

  // Counts high samples and rising edges of one channel over one aligned period,
  // optionally issuing a single register write at sample wr_at.
  task automatic measure(input int ch, input int wr_at, input logic [7:0] wa,
                         input logic [7:0] wd, output int highs, output int rises);
    logic prev;
    wait_tick();
    highs = 0;
    rises = 0;
    prev  = 1'b0;
    for (int s = 0; s < PERIOD; s++) begin
      @(negedge clk);
      if (s == wr_at) begin
        bus_if.wen   = 1'b1;
        bus_if.addr  = wa;
        bus_if.wdata = wd;
      end else begin
        bus_if.wen = 1'b0;
      end
      if (pwm_out[ch]) highs++;
      if (pwm_out[ch] && !prev) rises++;
      prev = pwm_out[ch];
    end
    bus_if.wen = 1'b0;
  endtask

  // Polls level[0] until it equals v; n returns the cycles spent.
  task automatic wait_level(input string name, input logic [7:0] v, input int bound, output int n);
    n = 0;
    do begin
      @(negedge clk);
      bus_if.addr = 8'h20;
      #1;
      n++;
    end while (bus_if.rdata !== v && n < bound);
    check(name, {24'b0, bus_if.rdata}, {24'b0, v});
  endtask

  initial begin
    logic [7:0] d;
    int highs, rises, n;

    // Reset
    rst_n        = 1'b0;
    manual_in    = 8'h00;
    bus_if.wen   = 1'b0;
    bus_if.addr  = 8'h00;
    bus_if.wdata = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_pwm_out", {24'b0, pwm_out}, 32'd0);
    check("rst_tick", {31'b0, period_tick}, 32'd0);
    rst_n = 1'b1;

    // Register / manual-mode vectors
    vecs[0]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h10, 8'h00, "ctrl_reset"};
    vecs[1]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h11, 8'h01, "fadediv_reset"};
    vecs[2]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, "tgt0_man00"};
    vecs[3]  = '{8'h00, 1'b0, 8'h00, 8'h00, 8'h20, 8'h00, "lvl0_man00"};
    vecs[4]  = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h00, 8'h80, "tgt0_man80"};
    vecs[5]  = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h01, 8'h90, "tgt1_man80"};
    vecs[6]  = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h20, 8'h80, "lvl0_man80"};
    vecs[7]  = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h27, 8'hF0, "lvl7_man80"};
    vecs[8]  = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h08, 8'h00, "unlisted_08"};
    vecs[9]  = '{8'h80, 1'b0, 8'h00, 8'h00, 8'h15, 8'h00, "unlisted_15"};
    vecs[10] = '{8'h80, 1'b1, 8'h50, 8'h55, 8'h50, 8'h00, "ignored_wr_50"};
    vecs[11] = '{8'h80, 1'b1, 8'h12, 8'hAA, 8'h10, 8'h00, "ctrl_untouched"};
    vecs[12] = '{8'h80, 1'b1, 8'h11, 8'h00, 8'h11, 8'h00, "fadediv_wr0"};
    vecs[13] = '{8'h80, 1'b1, 8'h11, 8'h01, 8'h11, 8'h01, "fadediv_wr1"};
    vecs[14] = '{8'h80, 1'b1, 8'h10, 8'hFC, 8'h10, 8'h00, "ctrl_hi_bits"};

    for (int v = 0; v < 15; v++) begin
      manual_in = vecs[v].manual;
      if (vecs[v].do_wr) wr(vecs[v].wa, vecs[v].wd);
      repeat (3) @(negedge clk);
      rd(vecs[v].ra, d);
      check(vecs[v].name, {24'b0, d}, {24'b0, vecs[v].exp});
    end

    // Exp-mapped duty under manual_in=0x80: ch0 L=0x80 -> 1, ch1 L=0x90 -> 2, ch7 L=0xF0 -> 128
    measure(0, -1, 8'h00, 8'h00, highs, rises);
    check("ch0_highs", highs, 1);
    check("ch0_rises", rises, 1);
    measure(1, -1, 8'h00, 8'h00, highs, rises);
    check("ch1_highs", highs, 2);
    measure(7, -1, 8'h00, 8'h00, highs, rises);
    check("ch7_highs", highs, 128);

    // Full-on channel in register mode; manual input ignored afterwards
    wr(8'h03, 8'hFF);
    rd(8'h10, d);
    check("reg_mode_set", {24'b0, d}, 32'h01);
    manual_in = 8'h22;
    repeat (4) @(negedge clk);
    rd(8'h00, d);
    check("manual_ignored", {24'b0, d}, 32'h80);
    rd(8'h23, d);
    check("lvl3_full", {24'b0, d}, 32'hFF);
    wait_tick();
    measure(3, -1, 8'h00, 8'h00, highs, rises);
    check("ch3_full_highs", highs, PERIOD);

    // Mid-period retarget: width changes only at the next wrap, one clean pulse
    wr(8'h02, 8'hF0);
    measure(2, 50, 8'h02, 8'h90, highs, rises);
    check("mid_wr_highs", highs, 128);
    check("mid_wr_rises", rises, 1);
    measure(2, -1, 8'h00, 8'h00, highs, rises);
    check("after_wrap_highs", highs, 2);

    // Fader with fade_div=2
    wr(8'h00, 8'h00);
    repeat (3) @(negedge clk);
    wr(8'h11, 8'h02);
    wr(8'h10, 8'h03);
    wr(8'h00, 8'h05);
    for (int k = 1; k <= 5; k++) begin
      wait_level($sformatf("fade_up_%0d", k), 8'(k), 3 * 2 * PERIOD, n);
      if (k > 1) check($sformatf("fade_gap_%0d", k), n, 2 * PERIOD);
    end
    repeat (1100) @(negedge clk);
    rd(8'h20, d);
    check("fade_hold5", {24'b0, d}, 32'h05);

    // Retarget mid-fade downwards without overshoot
    wr(8'h00, 8'h01);
    wait_level("fade_dn_4", 8'h04, 3 * 2 * PERIOD, n);
    wr(8'h00, 8'h03);
    wait_level("fade_dn_3", 8'h03, 3 * 2 * PERIOD, n);
    repeat (1100) @(negedge clk);
    rd(8'h20, d);
    check("fade_hold3", {24'b0, d}, 32'h03);

    // fade_div=0 steps every period
    wr(8'h11, 8'h00);
    wr(8'h00, 8'h06);
    wait_level("div0_4", 8'h04, 3 * PERIOD, n);
    wait_level("div0_5", 8'h05, 3 * PERIOD, n);
    check("div0_gap5", n, PERIOD);
    wait_level("div0_6", 8'h06, 3 * PERIOD, n);
    check("div0_gap6", n, PERIOD);

    // Asynchronous reset in the middle of a period with a fade running
    wr(8'h11, 8'h02);
    wr(8'h00, 8'h40);
    wait_level("pre_rst_7", 8'h07, 3 * 2 * PERIOD, n);
    wait_tick();
    repeat (100) @(negedge clk);
    check("pre_rst_ch3", {31'b0, pwm_out[3]}, 32'd1);
    manual_in = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_pwm", {24'b0, pwm_out}, 32'd0);
    check("rst_mid_tick", {31'b0, period_tick}, 32'd0);
    rd(8'h10, d);
    check("rst_mid_ctrl", {24'b0, d}, 32'h00);
    rd(8'h11, d);
    check("rst_mid_div", {24'b0, d}, 32'h01);
    rd(8'h20, d);
    check("rst_mid_lvl0", {24'b0, d}, 32'h00);
    rd(8'h03, d);
    check("rst_mid_tgt3", {24'b0, d}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_tick && n < 600);
    check("restart_cnt", n, PERIOD - 1);
    measure(3, -1, 8'h00, 8'h00, highs, rises);
    check("post_rst_ch3", highs, 0);
    rd(8'h10, d);
    check("post_rst_ctrl", {24'b0, d}, 32'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
